// File: rtl/mem_byte_sequencer.sv
`default_nettype none
// mem_byte_sequencer: serialises 8/16/32-bit core loads/stores into little-endian byte
// accesses on a byte-wide RAM port, reassembles loads with extension, aborts on a stalled RAM.
module mem_byte_sequencer #(
  parameter int ADDR_WIDTH = 14,
  parameter int TIMEOUT    = 15
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_request,
  input  logic                  i_write,
  input  logic [1:0]            i_size,
  input  logic                  i_unsigned,
  input  logic [31:0]           i_address,
  input  logic [31:0]           i_data,
  output logic [31:0]           o_data,
  output logic                  o_done,
  output logic                  o_error,
  output logic                  o_busy,
  output logic                  o_ram_request,
  output logic                  o_ram_write,
  output logic [ADDR_WIDTH-1:0] o_ram_address,
  output logic [7:0]            o_ram_data,
  input  logic [7:0]            i_ram_data,
  input  logic                  i_ram_data_DV
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] base, base_n;
  logic [31:0]           wdata, wdata_n;
  logic [31:0]           asm_q, asm_n;
  logic [1:0]            size_q, size_n;
  logic                  write_q, write_n;
  logic                  unsigned_q, unsigned_n;
  logic [1:0]            k, k_n;
  logic [TW-1:0]         tcnt, tcnt_n, tcnt_inc;
  logic                  err, err_n;
  logic                  go_req, go_done;

  logic [31:0]           data_n;
  logic                  done_n, error_n, busy_n, rreq_n, rwr_n;
  logic [ADDR_WIDTH-1:0] raddr_n;
  logic [7:0]            rdata_n;

  function automatic logic [1:0] last_idx(input logic [1:0] sz);
    case (sz)
      2'd0:    last_idx = 2'd0;
      2'd1:    last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] sz,
                                         input logic uns);
    case (sz)
      2'd0:    extend = {{24{v[7] & ~uns}}, v[7:0]};
      2'd1:    extend = {{16{v[15] & ~uns}}, v[15:0]};
      default: extend = v;
    endcase
  endfunction

  assign tcnt_inc = tcnt + TW'(1);

  generate
    if (ADDR_WIDTH < 32) begin : g_addr_unused
      logic unused_addr_bits;
      assign unused_addr_bits = ^i_address[31:ADDR_WIDTH];
    end
  endgenerate

  always_comb begin
    state_n    = state;
    base_n     = base;
    wdata_n    = wdata;
    asm_n      = asm_q;
    size_n     = size_q;
    write_n    = write_q;
    unsigned_n = unsigned_q;
    k_n        = k;
    tcnt_n     = tcnt;
    err_n      = err;
    go_req     = 1'b0;
    go_done    = 1'b0;
    data_n     = o_data;
    done_n     = 1'b0;
    error_n    = 1'b0;
    rreq_n     = 1'b0;
    rwr_n      = 1'b0;
    raddr_n    = o_ram_address;
    rdata_n    = o_ram_data;

    case (state)
      IDLE: begin
        if (i_request) begin
          base_n     = i_address[ADDR_WIDTH-1:0];
          wdata_n    = i_data;
          size_n     = i_size;
          write_n    = i_write;
          unsigned_n = i_unsigned;
          asm_n      = '0;
          err_n      = 1'b0;
          k_n        = 2'd0;
          go_req     = 1'b1;
        end
      end
      REQ: begin
        tcnt_n  = '0;
        state_n = WAIT;
      end
      WAIT: begin
        if (i_ram_data_DV) begin
          if (!write_q) asm_n[{k, 3'b000} +: 8] = i_ram_data;
          if (k == last_idx(size_q)) begin
            go_done = 1'b1;
          end else begin
            k_n    = k + 2'd1;
            go_req = 1'b1;
          end
        end else if (TIMEOUT != 0) begin
          if (tcnt_inc == TW'(TIMEOUT)) begin
            err_n   = 1'b1;
            go_done = 1'b1;
          end else begin
            tcnt_n = tcnt_inc;
          end
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Outputs are loaded on entry to REQ/DONE so they are valid for that whole cycle.
    if (go_req) begin
      state_n = REQ;
      rreq_n  = 1'b1;
      rwr_n   = write_n;
      raddr_n = base_n + ADDR_WIDTH'(k_n);
      rdata_n = wdata_n[{k_n, 3'b000} +: 8];
    end
    if (go_done) begin
      state_n = DONE;
      done_n  = 1'b1;
      error_n = err_n;
      if (!write_q && !err_n) data_n = extend(asm_n, size_q, unsigned_q);
    end
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      base          <= '0;
      wdata         <= '0;
      asm_q         <= '0;
      size_q        <= 2'd0;
      write_q       <= 1'b0;
      unsigned_q    <= 1'b0;
      k             <= 2'd0;
      tcnt          <= '0;
      err           <= 1'b0;
      o_data        <= '0;
      o_done        <= 1'b0;
      o_error       <= 1'b0;
      o_busy        <= 1'b0;
      o_ram_request <= 1'b0;
      o_ram_write   <= 1'b0;
      o_ram_address <= '0;
      o_ram_data    <= '0;
    end else begin
      state         <= state_n;
      base          <= base_n;
      wdata         <= wdata_n;
      asm_q         <= asm_n;
      size_q        <= size_n;
      write_q       <= write_n;
      unsigned_q    <= unsigned_n;
      k             <= k_n;
      tcnt          <= tcnt_n;
      err           <= err_n;
      o_data        <= data_n;
      o_done        <= done_n;
      o_error       <= error_n;
      o_busy        <= busy_n;
      o_ram_request <= rreq_n;
      o_ram_write   <= rwr_n;
      o_ram_address <= raddr_n;
      o_ram_data    <= rdata_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_byte_sequencer.sv
`default_nettype none
// tb_mem_byte_sequencer: directed and random transactions against a byte-RAM responder and a
// transaction-level reference of the sequencer.
module tb_mem_byte_sequencer;
  localparam int AW = 14;
  localparam int T  = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic request = 1'b0, write = 1'b0, uns = 1'b0;
  logic [1:0] size = 2'd0;
  logic [31:0] address = '0, wdata = '0;
  logic [31:0] rdata;
  logic done, error, busy, ram_req, ram_wr;
  logic [AW-1:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata = '0;
  logic ram_dv = 1'b0;

  always #5 clk = ~clk;

  mem_byte_sequencer #(.ADDR_WIDTH(AW), .TIMEOUT(T)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_request(request), .i_write(write), .i_size(size),
    .i_unsigned(uns), .i_address(address), .i_data(wdata), .o_data(rdata), .o_done(done),
    .o_error(error), .o_busy(busy), .o_ram_request(ram_req), .o_ram_write(ram_wr),
    .o_ram_address(ram_addr), .o_ram_data(ram_wdata), .i_ram_data(ram_rdata),
    .i_ram_data_DV(ram_dv)
  );

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] dlys;   // per-byte RAM response delay, byte j in bits [8j+7:8j]
  } txn_t;

  typedef struct packed {
    logic [AW-1:0] a;
    logic          w;
    logic [7:0]    d;
  } acc_t;

  txn_t txq[$];
  acc_t accq[$];
  int   req_cyc[$];
  logic [AW-1:0] req_addr[$];

  logic [7:0]  mem [0:(1<<AW)-1];
  logic [31:0] cur_dlys = '0;

  int          cyc = 0, start_cyc = 0, exp_cyc = 0, done_count = 0, last_cyc = 0;
  logic [31:0] cur_data = '0, exp_data = '0, last_data = '0;
  logic        exp_err = 1'b0, last_err = 1'b0, in_txn = 1'b0;
  logic        prev_busy = 1'b0, prev_done = 1'b0;

  // Byte RAM: acknowledges each request after the scheduled delay, with ignored DV noise.
  initial begin : responder
    bit pending, dbl, dbl_now;
    int cnt, bi;
    logic [7:0] rd;
    pending = 0; dbl = 0; cnt = 0; bi = 0; rd = '0;
    forever begin
      @(negedge clk);
      ram_dv  = 1'b0;
      dbl_now = dbl;
      dbl     = 0;
      if (!rst_n) begin
        pending = 0;
        bi      = 0;
      end else begin
        if (done) pending = 0;
        if (!busy) bi = 0;
        if (pending) begin
          if (cnt == 0) begin
            ram_dv    = 1'b1;
            ram_rdata = rd;
            pending   = 0;
            dbl       = ($urandom_range(0, 3) == 0);
          end else begin
            cnt--;
          end
        end else if (ram_req) begin
          if (ram_wr) mem[ram_addr] = ram_wdata;
          rd        = mem[ram_addr];
          cnt       = int'(cur_dlys[8*bi +: 8]);
          bi++;
          pending   = 1;
          ram_dv    = ($urandom_range(0, 3) == 0);
          ram_rdata = 8'($urandom);
        end else if (!busy || done) begin
          ram_dv    = ($urandom_range(0, 3) == 0);
          ram_rdata = 8'($urandom);
        end
        if (dbl_now && (ram_req || done)) ram_dv = 1'b1;
      end
    end
  end

  always @(negedge clk) begin : compare
    int rel, n, ec;
    bit er;
    txn_t t;
    acc_t e;
    logic [31:0] asmv, v, half;
    logic [AW-1:0] a;
    cyc++;
    if (!rst_n) begin
      accq.delete();
      in_txn    = 1'b0;
      cur_data  = '0;
      prev_busy = 1'b0;
      prev_done = 1'b0;
    end else begin
      rel = cyc - start_cyc + 1;
      if (busy && !prev_busy) begin
        chk("accept_has_txn", 32'(txq.size() != 0), 1);
        if (txq.size() != 0) begin
          t = txq.pop_front();
          n = (t.size == 2'd0) ? 1 : (t.size == 2'd1) ? 2 : 4;
          asmv = '0; ec = 0; er = 0;
          for (int j = 0; j < n; j++) begin
            a = AW'(t.addr + 32'(j));
            accq.push_back('{a, t.wr, t.data[8*j +: 8]});
            if (int'(t.dlys[8*j +: 8]) >= T) begin
              er = 1;
              ec += 1 + T;
              break;
            end
            ec += 2 + int'(t.dlys[8*j +: 8]);
            asmv[8*j +: 8] = mem[a];
          end
          exp_cyc  = ec + 1;
          exp_err  = er;
          exp_data = cur_data;
          if (!t.wr && !er) begin
            v = asmv;
            if (n < 4) begin
              half = (n == 1) ? 32'd128 : 32'd32768;
              if (!t.uns && v >= half) v = v - 2 * half;
            end
            exp_data = v;
          end
          start_cyc = cyc;
          rel       = 1;
          in_txn    = 1'b1;
        end
      end
      if (ram_req) begin
        chk("req_expected", 32'(accq.size() != 0), 1);
        if (accq.size() != 0) begin
          e = accq.pop_front();
          chk("ram_addr", 32'(ram_addr), 32'(e.a));
          chk("ram_write", 32'(ram_wr), 32'(e.w));
          chk("ram_data", 32'(ram_wdata), 32'(e.d));
        end
        req_cyc.push_back(rel);
        req_addr.push_back(ram_addr);
      end else begin
        chk("ram_write_idle", 32'(ram_wr), 0);
      end
      if (done) begin
        done_count++;
        chk("done_in_txn", 32'(in_txn), 1);
        chk("done_cycle", 32'(rel), 32'(exp_cyc));
        chk("done_error", 32'(error), 32'(exp_err));
        chk("done_busy", 32'(busy), 1);
        chk("acc_left", 32'(accq.size()), 0);
        if (in_txn) cur_data = exp_data;
        last_cyc  = rel;
        last_data = rdata;
        last_err  = error;
        in_txn    = 1'b0;
      end else begin
        chk("error_low", 32'(error), 0);
        if (in_txn && rel >= exp_cyc) begin
          chk("done_missing", 32'(done), 1);
          in_txn = 1'b0;
        end
      end
      chk("o_data", rdata, cur_data);
      if (prev_done) chk("busy_after_done", 32'(busy), 0);
      prev_busy = busy;
      prev_done = done;
    end
  end

  task automatic start(input logic wr, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d, input logic [31:0] dl);
    int g;
    g = 0;
    @(negedge clk);
    while (busy && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (busy) chk("idle_wait", 32'(busy), 0);
    cur_dlys = dl;
    request  = 1'b1;
    write    = wr;
    size     = sz;
    uns      = u;
    address  = a;
    wdata    = d;
    txq.push_back('{wr, sz, u, a, d, dl});
  endtask

  task automatic scramble();
    write   = 1'($urandom);
    size    = 2'($urandom);
    uns     = 1'($urandom);
    address = $urandom;
    wdata   = $urandom;
  endtask

  task automatic issue(input logic wr, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d, input logic [31:0] dl,
                       input int extra);
    int n0, g;
    n0 = done_count;
    start(wr, sz, u, a, d, dl);
    for (int i = 0; i < extra; i++) begin
      @(negedge clk);
      scramble();
    end
    @(negedge clk);
    request = 1'b0;
    scramble();
    g = 0;
    while (done_count == n0 && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (done_count == n0) chk("done_timeout", 32'(done_count), 32'(n0 + 1));
  endtask

  task automatic clear_logs();
    req_cyc.delete();
    req_addr.delete();
  endtask

  initial begin : main
    int n0;
    logic [31:0] dl;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", rdata, 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ram_req", 32'(ram_req), 0);
    chk("rst_ram_wr", 32'(ram_wr), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_ram_data", 32'(ram_wdata), 0);
    #2 rst_n = 1'b1;

    clear_logs();
    issue(1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 0);
    chk("ws_mem10", 32'(mem[14'h10]), 32'hEF);
    chk("ws_mem11", 32'(mem[14'h11]), 32'hBE);
    chk("ws_mem12", 32'(mem[14'h12]), 32'hAD);
    chk("ws_mem13", 32'(mem[14'h13]), 32'hDE);
    chk("ws_nreq", 32'(req_cyc.size()), 4);
    if (req_cyc.size() == 4) begin
      chk("ws_req0_cyc", 32'(req_cyc[0]), 1);
      chk("ws_req1_cyc", 32'(req_cyc[1]), 3);
      chk("ws_req2_cyc", 32'(req_cyc[2]), 5);
      chk("ws_req3_cyc", 32'(req_cyc[3]), 7);
    end
    chk("ws_done_cyc", 32'(last_cyc), 9);
    chk("ws_err", 32'(last_err), 0);
    chk("ws_data", last_data, 0);

    mem[14'h12] = 8'h80;
    mem[14'h13] = 8'hFF;
    issue(1'b0, 2'd0, 1'b0, 32'h0000_0012, 32'h0, 32'h0, 0);
    chk("lb_signed", last_data, 32'hFFFF_FF80);
    chk("lb_cyc", 32'(last_cyc), 3);
    issue(1'b0, 2'd0, 1'b1, 32'h0000_0012, 32'h0, 32'h0, 0);
    chk("lb_unsigned", last_data, 32'h0000_0080);
    issue(1'b0, 2'd1, 1'b0, 32'h0000_0012, 32'h0, 32'h0, 0);
    chk("lh_signed", last_data, 32'hFFFF_FF80);
    chk("lh_cyc", 32'(last_cyc), 5);

    mem[14'h3FFE] = 8'h11;
    mem[14'h3FFF] = 8'h22;
    mem[14'h0000] = 8'h33;
    mem[14'h0001] = 8'h44;
    clear_logs();
    issue(1'b0, 2'd2, 1'b0, 32'hABC0_3FFE, 32'h0, 32'h0, 0);
    chk("wrap_nreq", 32'(req_addr.size()), 4);
    if (req_addr.size() == 4) begin
      chk("wrap_a0", 32'(req_addr[0]), 32'h3FFE);
      chk("wrap_a1", 32'(req_addr[1]), 32'h3FFF);
      chk("wrap_a2", 32'(req_addr[2]), 32'h0000);
      chk("wrap_a3", 32'(req_addr[3]), 32'h0001);
    end
    chk("wrap_data", last_data, 32'h4433_2211);

    clear_logs();
    issue(1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'h0, 32'h0000_0014, 0);
    chk("to_nreq", 32'(req_cyc.size()), 1);
    chk("to_cyc", 32'(last_cyc), 32'(T + 2));
    chk("to_err", 32'(last_err), 1);
    chk("to_data", last_data, 32'h4433_2211);
    repeat (5) @(negedge clk);
    chk("to_no_more_req", 32'(req_cyc.size()), 1);

    clear_logs();
    n0 = done_count;
    issue(1'b1, 2'd2, 1'b0, 32'h0000_0040, 32'h1234_5678, 32'h0, 2);
    repeat (4) @(negedge clk);
    chk("busy_ign_nreq", 32'(req_cyc.size()), 4);
    chk("busy_ign_ndone", 32'(done_count - n0), 1);
    chk("busy_ign_cyc", 32'(last_cyc), 9);

    start(1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'hCAFE_F00D, 32'h0);
    @(negedge clk);
    request = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_mid_pre_busy", 32'(busy), 1);
    n0 = done_count;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ram_req", 32'(ram_req), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_done", 32'(done), 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_mid_no_done", 32'(done_count), 32'(n0));
    issue(1'b0, 2'd0, 1'b1, 32'h0000_0000, 32'h0, 32'h0, 0);
    chk("post_rst_cyc", 32'(last_cyc), 3);
    chk("post_rst_data", last_data, 32'h0000_0033);

    for (int i = 0; i < 200; i++) begin
      for (int j = 0; j < 4; j++)
        dl[8*j +: 8] = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(T - 1, T + 2))
                                                   : 8'($urandom_range(0, 2));
      issue(1'($urandom), 2'($urandom),
            1'($urandom),
            ($urandom_range(0, 3) == 0) ? (32'h0000_3FFC | 32'($urandom_range(0, 3))) : $urandom,
            $urandom, dl, $urandom_range(0, 2));
    end
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_byte_sequencer.md
Name: mem_byte_sequencer

Overview:
- Sits directly upstream of the 8-bit cache RAM port A, between the core's load/store unit and the byte-wide read/write port.
- Accepts one 8-, 16- or 32-bit load/store per transaction and serialises it into little-endian byte accesses on the RAM port.
- Reassembles load data with sign or zero extension.
- Reports completion with a one-cycle done pulse, and aborts with an error if the RAM stops answering.

Parameters:
- ADDR_WIDTH, 14, byte-address width of the RAM port; the core address is truncated to this width.
- TIMEOUT, 15, maximum cycles spent waiting for i_ram_data_DV per byte before abort; 0 disables the watchdog.

Ports:
- i_clk  in  1  system clock, all state on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_request  in  1  core request strobe, sampled only in IDLE
- i_write  in  1  1 = store, 0 = load
- i_size  in  2  0 = byte, 1 = half, 2 = word, 3 = treated as word
- i_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
- i_address  in  32  byte address; low ADDR_WIDTH bits used
- i_data  in  32  store data, little-endian
- o_data  out  32  load result, valid when o_done=1, held until next load completes
- o_done  out  1  one-cycle completion pulse, for loads and stores
- o_error  out  1  high with o_done when the transaction was aborted by timeout
- o_busy  out  1  high whenever the state is not IDLE
- o_ram_request  out  1  RAM access strobe, to RAM i_request
- o_ram_write  out  1  RAM write enable, to RAM i_write
- o_ram_address  out  ADDR_WIDTH  RAM byte address
- o_ram_data  out  8  RAM write data
- i_ram_data  in  8  RAM read data
- i_ram_data_DV  in  1  RAM data-valid/acknowledge

Behaviour:
- Reset: async on i_rst_n=0.
  - State IDLE.
  - o_data=0, o_done=0, o_error=0, o_busy=0.
  - o_ram_request=0, o_ram_write=0, o_ram_address=0, o_ram_data=0.
  - Byte counter and timeout counter = 0.
- All outputs are driven from registers; there is no combinational path from any input to any output.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If i_request=1, latch i_address, i_data, i_size, i_write and i_unsigned.
  - Set byte count N = 1/2/4 from size, counter k=0, then go to REQ.
  - Otherwise stay in IDLE.
- REQ (exactly one cycle):
  - o_ram_request=1.
  - o_ram_address = (base + k) mod 2^ADDR_WIDTH, so the address wraps to 0.
  - o_ram_write = latched write.
  - o_ram_data = byte k of the latched data.
  - Clear the timeout counter, then go to WAIT.
  - o_ram_request and o_ram_write are 0 in every other state.
- WAIT:
  - On i_ram_data_DV=1 during a load, capture i_ram_data into byte lane k.
  - After the DV: if k = N-1, go to DONE; otherwise k++ and go to REQ.
  - With no DV, the timeout counter increments. When it reaches TIMEOUT (TIMEOUT>0), set the error flag and go to DONE.
- DONE (one cycle):
  - o_done=1.
  - o_error = error flag.
  - Completed load without error: o_data = assembled value, extended per size/unsigned.
    - Byte load: bits [31:8] are all bit 7 (signed) or 0 (unsigned).
    - Half load: bits [31:16] are all bit 15 (signed) or 0 (unsigned).
  - Stores and aborted loads leave o_data unchanged.
  - Go to IDLE; o_busy drops in the same cycle.
- Latency, with the request accepted at edge 0 and DV arriving the cycle after each REQ:
  - Byte: REQ cycle 1, done cycle 3.
  - Half: REQ cycles 1 and 3, done cycle 5.
  - Word: REQ cycles 1, 3, 5 and 7, done cycle 9.
  - The next request can be accepted in the cycle after DONE.
- Misaligned accesses are legal. Each byte is a separate access, so alignment is irrelevant.
- Boundary and ignore rules:
  - i_request while o_busy=1 is ignored, not queued.
  - Changes to the core inputs after acceptance have no effect.
  - i_ram_data_DV in IDLE, REQ or DONE is ignored.
  - Only the first DV in WAIT advances the state.
  - Aborting on timeout issues no further RAM requests for that transaction; the error flag clears on the next accept.
- Reset mid-transaction returns to IDLE immediately. o_ram_request drops asynchronously, and the partial transaction is discarded with no o_done.

Test Plan:
- Word store: addr 0x0010, data 0xDEADBEEF. RAM sees writes 0x10=EF, 0x11=BE, 0x12=AD, 0x13=DE in cycles 1, 3, 5, 7. o_done=1 and o_error=0 in cycle 9; o_data unchanged.
- Byte loads at 0x0012 with RAM holding 0x80: signed gives o_data=0xFFFFFF80 in cycle 3; unsigned gives 0x00000080. Signed half at 0x0012 with bytes 80 FF gives 0xFFFFFF80.
- Wrap-around: word load at 0x3FFE with ADDR_WIDTH=14 and RAM 3FFE=11, 3FFF=22, 0000=33, 0001=44. Addresses issued are 3FFE, 3FFF, 0000, 0001, and o_data=0x44332211.
- Timeout: word load with DV held low for 20 cycles. A single request is issued, then o_done=1 and o_error=1 exactly TIMEOUT cycles after entering WAIT. No further o_ram_request; o_data keeps its prior value.
- Busy ignore: second i_request in cycle 2 of a word store produces no extra RAM traffic, and only one o_done is seen.
- Reset mid-op: assert i_rst_n=0 during WAIT of byte 2 of a word store. o_ram_request=0, o_busy=0 and no o_done. After release, a byte load at 0x0000 completes in 3 cycles.
